// File: rtl/room_temp_model_if.sv
// Link between the AC controller (master) and the thermal plant (slave); demands in, temperature out.
// Purely combinational wiring; no handshake or backpressure, the plant reads demands on its step edges.
interface room_temp_model_if;
  logic       heating;
  logic       cooling;
  logic       hold;
  logic       load;
  logic [4:0] load_temp;
  logic [4:0] temperature;
  logic       temp_valid;
  logic [1:0] mode;
  logic       fault;

  modport master (
    output heating, cooling, hold, load, load_temp,
    input  temperature, temp_valid, mode, fault
  );

  modport slave (
    input  heating, cooling, hold, load, load_temp,
    output temperature, temp_valid, mode, fault
  );
endinterface

// File: rtl/room_temp_model.sv
// Thermal plant: temperature steps every TICK_DIV clocks (heat/cool/drift), result and temp_valid one cycle later.
// No backpressure: hold freezes stepping; load overwrites temperature and restarts the step timing.
module room_temp_model #(
  parameter int         TICK_DIV  = 4,
  parameter int         DRIFT_DIV = 4,
  parameter logic [4:0] INIT_TEMP = 5'd18,
  parameter logic [4:0] AMBIENT   = 5'd15
) (
  input  logic              clk,
  input  logic              rst,
  room_temp_model_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_HEAT = 2'b01,
    MODE_COOL = 2'b10
  } mode_t;

  localparam int              PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PSC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      DRIFT_LAST = 8'(DRIFT_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    drift_cnt;
  logic          heat_req;
  logic          cool_req;
  logic          step_edge;

  // Both demands high is a fault and is treated as idle by the plant.
  always_comb begin
    heat_req  = bus.heating & ~bus.cooling;
    cool_req  = bus.cooling & ~bus.heating;
    step_edge = (prescaler == PSC_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.temperature <= INIT_TEMP;
      bus.temp_valid  <= 1'b0;
      bus.mode        <= MODE_IDLE;
      bus.fault       <= 1'b0;
      prescaler       <= '0;
      drift_cnt       <= '0;
    end else begin
      bus.fault <= bus.fault | (bus.heating & bus.cooling);
      if (bus.load) begin
        bus.temperature <= bus.load_temp;
        bus.temp_valid  <= 1'b1;
        prescaler       <= '0;
        drift_cnt       <= '0;
      end else if (bus.hold) begin
        bus.temp_valid  <= 1'b0;
      end else if (step_edge) begin
        prescaler      <= '0;
        bus.temp_valid <= 1'b1;
        if (heat_req) begin
          bus.mode  <= MODE_HEAT;
          drift_cnt <= '0;
          if (bus.temperature != 5'd31) bus.temperature <= bus.temperature + 5'd1;
        end else if (cool_req) begin
          bus.mode  <= MODE_COOL;
          drift_cnt <= '0;
          if (bus.temperature != 5'd0) bus.temperature <= bus.temperature - 5'd1;
        end else begin
          bus.mode <= MODE_IDLE;
          if (drift_cnt == DRIFT_LAST) begin
            drift_cnt <= '0;
            if (bus.temperature > AMBIENT)      bus.temperature <= bus.temperature - 5'd1;
            else if (bus.temperature < AMBIENT) bus.temperature <= bus.temperature + 5'd1;
          end else begin
            drift_cnt <= drift_cnt + 8'd1;
          end
        end
      end else begin
        prescaler      <= prescaler + 1'b1;
        bus.temp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_room_temp_model.sv
// Directed bench for room_temp_model: arithmetic plant model checked every cycle plus hand-computed pins.
module tb_room_temp_model;
  localparam int TICK_DIV  = 4;
  localparam int DRIFT_DIV = 4;
  localparam int INIT_TEMP = 18;
  localparam int AMBIENT   = 15;

  logic clk;
  logic rst;
  room_temp_model_if bus();

  room_temp_model #(
    .TICK_DIV(TICK_DIV), .DRIFT_DIV(DRIFT_DIV),
    .INIT_TEMP(5'(INIT_TEMP)), .AMBIENT(5'(AMBIENT))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plant model: counts unheld edges since the last restart; every TICK_DIV-th one is a step.
  int m_temp, m_run, m_idle, m_mode, m_valid, m_fault;

  always @(posedge clk) begin
    if (rst) begin
      m_temp = INIT_TEMP; m_run = 0; m_idle = 0; m_mode = 0; m_valid = 0; m_fault = 0;
    end else begin
      if (bus.heating && bus.cooling) m_fault = 1;
      if (bus.load) begin
        m_temp = int'(bus.load_temp); m_run = 0; m_idle = 0; m_valid = 1;
      end else if (bus.hold) begin
        m_valid = 0;
      end else begin
        m_run++;
        m_valid = (m_run % TICK_DIV == 0) ? 1 : 0;
        if (m_valid == 1) begin
          if (bus.heating && !bus.cooling) begin
            m_mode = 1; m_idle = 0;
            m_temp = (m_temp + 1 > 31) ? 31 : m_temp + 1;
          end else if (bus.cooling && !bus.heating) begin
            m_mode = 2; m_idle = 0;
            m_temp = (m_temp - 1 < 0) ? 0 : m_temp - 1;
          end else begin
            m_mode = 0; m_idle++;
            if (m_idle % DRIFT_DIV == 0) begin
              if (m_temp > AMBIENT) m_temp--;
              else if (m_temp < AMBIENT) m_temp++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_temperature", int'(bus.temperature), m_temp);
      chk("model_temp_valid",  int'(bus.temp_valid),  m_valid);
      chk("model_mode",        int'(bus.mode),        m_mode);
      chk("model_fault",       int'(bus.fault),       m_fault);
    end
  end

  int vcnt;

  task automatic run(input int n);
    vcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.temp_valid) vcnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.heating = 0; bus.cooling = 0; bus.hold = 0; bus.load = 0; bus.load_temp = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_temp", int'(bus.temperature), 18);
    chk("reset_valid", int'(bus.temp_valid), 0);
    chk("reset_mode", int'(bus.mode), 0);
    chk("reset_fault", int'(bus.fault), 0);

    // 1: heat from reset, first step on the 4th edge
    rst = 1'b0; bus.heating = 1;
    run(3);
    chk("heat_pre_first_step", int'(bus.temperature), 18);
    @(negedge clk);
    chk("heat_first_step", int'(bus.temperature), 19);
    chk("heat_first_valid", int'(bus.temp_valid), 1);
    run(36);
    chk("heat_40_temp", int'(bus.temperature), 28);
    chk("heat_40_mode", int'(bus.mode), 1);
    chk("heat_valid_pulses", vcnt, 9);

    // 2: load 30 then heat, saturate at 31
    bus.load = 1; bus.load_temp = 5'd30;
    @(negedge clk);
    bus.load = 0;
    chk("load30_temp", int'(bus.temperature), 30);
    chk("load30_valid", int'(bus.temp_valid), 1);
    run(16);
    chk("heat_sat_temp", int'(bus.temperature), 31);
    chk("heat_sat_pulses", vcnt, 4);

    // 3: load 1 then cool, saturate at 0
    bus.heating = 0; bus.cooling = 1; bus.load = 1; bus.load_temp = 5'd1;
    @(negedge clk);
    bus.load = 0;
    run(16);
    chk("cool_sat_temp", int'(bus.temperature), 0);
    chk("cool_mode", int'(bus.mode), 2);

    // 4: idle drift from reset toward ambient
    bus.cooling = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    run(15);
    chk("drift_edge15", int'(bus.temperature), 18);
    run(1);
    chk("drift_edge16", int'(bus.temperature), 17);
    run(16);
    chk("drift_edge32", int'(bus.temperature), 16);
    run(16);
    chk("drift_edge48", int'(bus.temperature), 15);
    run(16);
    chk("drift_at_ambient", int'(bus.temperature), 15);
    chk("drift_mode", int'(bus.mode), 0);

    // 5: both demands high for one cycle
    chk("fault_before", int'(bus.fault), 0);
    bus.heating = 1; bus.cooling = 1;
    @(negedge clk);
    bus.heating = 0; bus.cooling = 0;
    chk("fault_set", int'(bus.fault), 1);
    chk("fault_temp_same", int'(bus.temperature), 15);
    run(8);
    bus.load = 1; bus.load_temp = 5'd20;
    @(negedge clk);
    bus.load = 0;
    chk("fault_sticky_load", int'(bus.fault), 1);

    // 6: hold mid-heat, load overriding hold, reset at prescaler 2
    bus.heating = 1;
    run(2);
    bus.hold = 1;
    run(20);
    chk("hold_temp", int'(bus.temperature), 20);
    chk("hold_no_valid", vcnt, 0);
    bus.load = 1; bus.load_temp = 5'd7;
    @(negedge clk);
    bus.load = 0;
    chk("load_over_hold", int'(bus.temperature), 7);
    bus.hold = 0;
    run(6);
    chk("heat_after_load", int'(bus.temperature), 8);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_temp", int'(bus.temperature), 18);
    chk("midrst_valid", int'(bus.temp_valid), 0);
    chk("midrst_fault", int'(bus.fault), 0);
    run(8);
    chk("post_rst_heat", int'(bus.temperature), 20);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
